// File: rtl/pe_ctrl_pkg.sv
// Shared definitions for the PE-chain sequencer.
//   state_e : job sequencing states of pe_chain_ctrl
//   lat()   : cycles from an activation entering the chain to its psum
//             leaving the tail PE (two psum registers per PE)
//   clog2() : index width helper, never narrower than one bit
package pe_ctrl_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    CLEAR  = 3'd1,
    LOAD_W = 3'd2,
    STREAM = 3'd3,
    DRAIN  = 3'd4,
    DONE   = 3'd5
  } state_e;

  function automatic int lat(input int num_pe);
    return 2 * num_pe;
  endfunction

  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 32; i++) begin
      if ((1 << r) < v) r = r + 1;
    end
    return (r < 1) ? 1 : r;
  endfunction

endpackage

// File: rtl/pe_chain_ctrl_vld_delay.sv
// vld_delay: fixed-depth valid shift register.
//   clk      : clock
//   rst      : asynchronous active-low reset, clears every stage
//   in       : valid bit entering the line
//   out      : valid bit DEPTH cycles after it entered
//   any_busy : OR of all stages, i.e. something is still in flight
module vld_delay #(
  parameter int DEPTH = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic in,
  output logic out,
  output logic any_busy
);

  logic [DEPTH-1:0] sr_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sr_q <= '0;
    end else begin
      sr_q <= {sr_q[DEPTH-2:0], in};
    end
  end

  assign out      = sr_q[DEPTH-1];
  assign any_busy = |sr_q;

endmodule

// File: rtl/pe_chain_ctrl.sv
// pe_chain_ctrl: sequencer for a linear chain of NUM_PE processing elements.
// One job per accepted start: clear the chain, load one weight per PE,
// stream cfg_len activations, then drain until the last psum leaves the tail.
//   clk, rst             : clock, asynchronous active-low reset
//   start, cfg_len       : job request (IDLE only) and activation count
//   busy, done           : not-IDLE flag, one-cycle end-of-job pulse
//   w_valid/w_ready/w_data : weight stream (one word per PE, in PE order)
//   a_valid/a_ready/a_data : activation stream
//   pe_clr               : synchronous clear to the PE chain
//   pe_w_en, pe_weight   : one-hot weight-load enable and registered weight
//   pe_act, pe_act_vld   : registered activation bus and its valid
//   psum_vld             : tail partial sum is valid this cycle
module pe_chain_ctrl
  import pe_ctrl_pkg::*;
#(
  parameter int NUM_PE = 8,
  parameter int D_W    = 64,
  parameter int A_W    = 16,
  parameter int LEN_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [LEN_W-1:0]  cfg_len,
  output logic              busy,
  output logic              done,
  input  logic              w_valid,
  output logic              w_ready,
  input  logic [D_W-1:0]    w_data,
  input  logic              a_valid,
  output logic              a_ready,
  input  logic [A_W-1:0]    a_data,
  output logic              pe_clr,
  output logic [NUM_PE-1:0] pe_w_en,
  output logic [D_W-1:0]    pe_weight,
  output logic [A_W-1:0]    pe_act,
  output logic              pe_act_vld,
  output logic              psum_vld
);

  localparam int LAT   = lat(NUM_PE);
  localparam int IDX_W = clog2(NUM_PE);

  state_e              state_q, state_d;
  logic [IDX_W-1:0]    w_idx_q, w_idx_d;
  logic [LEN_W-1:0]    a_cnt_q, a_cnt_d;
  logic [LEN_W-1:0]    len_q, len_d;

  logic                busy_q, done_q, pe_clr_q;
  logic [NUM_PE-1:0]   pe_w_en_q, pe_w_en_d;
  logic [D_W-1:0]      pe_weight_q, pe_weight_d;
  logic [A_W-1:0]      pe_act_q, pe_act_d;
  logic                pe_act_vld_q, pe_act_vld_d;
  logic                psum_vld_q;

  logic                w_hs, a_hs;
  logic                dl_out, dl_busy;

  // Ready flags decode straight from the state register.
  assign w_ready = (state_q == LOAD_W);
  assign a_ready = (state_q == STREAM);
  assign w_hs    = w_ready & w_valid;
  assign a_hs    = a_ready & a_valid;

  always_comb begin
    state_d      = state_q;
    w_idx_d      = w_idx_q;
    a_cnt_d      = a_cnt_q;
    len_d        = len_q;
    pe_w_en_d    = '0;
    pe_weight_d  = pe_weight_q;
    pe_act_d     = pe_act_q;
    pe_act_vld_d = 1'b0;

    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = CLEAR;
          len_d   = cfg_len;
        end
      end
      CLEAR: begin
        state_d = LOAD_W;
        w_idx_d = '0;
        a_cnt_d = '0;
      end
      LOAD_W: begin
        if (w_hs) begin
          pe_weight_d = w_data;
          pe_w_en_d   = NUM_PE'(1) << w_idx_q;
          w_idx_d     = w_idx_q + 1'b1;
          if (w_idx_q == IDX_W'(NUM_PE - 1)) begin
            state_d = (len_q == '0) ? DRAIN : STREAM;
          end
        end
      end
      STREAM: begin
        if (a_hs) begin
          pe_act_d     = a_data;
          pe_act_vld_d = 1'b1;
          a_cnt_d      = a_cnt_q + 1'b1;
          // len_q >= 1 here, so len_q-1 never wraps; a_cnt never overflows.
          if (a_cnt_q == len_q - 1'b1) state_d = DRAIN;
        end
      end
      DRAIN: begin
        // dl_busy covers everything still behind the psum_vld register, so
        // DONE lands the cycle after the final psum_vld.
        if (!dl_busy && !pe_act_vld_q) state_d = DONE;
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Registered outputs are computed from the next state so they line up
  // with the state they describe.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= IDLE;
      w_idx_q      <= '0;
      a_cnt_q      <= '0;
      len_q        <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      pe_clr_q     <= 1'b0;
      pe_w_en_q    <= '0;
      pe_weight_q  <= '0;
      pe_act_q     <= '0;
      pe_act_vld_q <= 1'b0;
      psum_vld_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      w_idx_q      <= w_idx_d;
      a_cnt_q      <= a_cnt_d;
      len_q        <= len_d;
      busy_q       <= (state_d != IDLE);
      done_q       <= (state_d == DONE);
      pe_clr_q     <= (state_d == CLEAR);
      pe_w_en_q    <= pe_w_en_d;
      pe_weight_q  <= pe_weight_d;
      pe_act_q     <= pe_act_d;
      pe_act_vld_q <= pe_act_vld_d;
      psum_vld_q   <= dl_out;
    end
  end

  // Valid delay line: LAT-1 stages here plus the psum_vld register give
  // exactly LAT cycles from pe_act_vld to psum_vld, bubbles preserved.
  vld_delay #(
    .DEPTH(LAT - 1)
  ) u_vld_delay (
    .clk     (clk),
    .rst     (rst),
    .in      (pe_act_vld_q),
    .out     (dl_out),
    .any_busy(dl_busy)
  );

  assign busy       = busy_q;
  assign done       = done_q;
  assign pe_clr     = pe_clr_q;
  assign pe_w_en    = pe_w_en_q;
  assign pe_weight  = pe_weight_q;
  assign pe_act     = pe_act_q;
  assign pe_act_vld = pe_act_vld_q;
  assign psum_vld   = psum_vld_q;

endmodule
